// File: rtl/pc_sequencer_if.sv
// Decoder/fetch-side bundle of the PC sequencer.
// The master drives the decoder strobes and the slave returns fetch/control state.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              im_ready;
    logic              halt;
    logic              jmp;
    logic [ADDR_W-1:0] jmp_target;
    logic              rti;
    logic              flags_wr_en;
    logic [3:0]        flags_in;
    logic              irq_req;
    logic              resume;
    logic [ADDR_W-1:0] pc;
    logic              commit;
    logic              halted;
    logic              in_isr;
    logic              irq_ack;
    logic [3:0]        flags_out;
    logic [ADDR_W-1:0] epc_out;

    modport master (
        output im_ready, halt, jmp, jmp_target, rti,
        output flags_wr_en, flags_in, irq_req, resume,
        input  pc, commit, halted, in_isr, irq_ack,
        input  flags_out, epc_out
    );

    modport slave (
        input  im_ready, halt, jmp, jmp_target, rti,
        input  flags_wr_en, flags_in, irq_req, resume,
        output pc, commit, halted, in_isr, irq_ack,
        output flags_out, epc_out
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC, flags and interrupt shadow state of the single-cycle core.
// Produces the next fetch address and the per-cycle commit strobe.
module pc_sequencer #(
    parameter int              ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [ADDR_W-1:0] IRQ_VECTOR   = 16'h0010
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_HALT = 2'd1;
    localparam logic [1:0] S_IRQ  = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic [3:0]        r_flags;
    logic [3:0]        r_sflags;
    logic              r_in_isr;
    logic              r_irq_ack;

    logic              w_commit;
    logic              w_rti_ok;
    logic              w_take_irq;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [3:0]        w_flags_nxt;

    assign w_commit   = reset && (r_state == S_RUN) && bus.im_ready;
    assign w_pc_inc   = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_rti_ok   = !bus.halt && bus.rti && r_in_isr;
    // in_isr sampled before the edge, so an rti never re-enters on its own edge
    assign w_take_irq = w_commit && bus.irq_req && !r_in_isr;

    always_comb begin
        w_pc_nxt = w_pc_inc;
        if (bus.halt)
            w_pc_nxt = w_pc_inc;
        else if (w_rti_ok)
            w_pc_nxt = r_epc;
        else if (bus.jmp)
            w_pc_nxt = bus.jmp_target;
    end

    always_comb begin
        w_flags_nxt = r_flags;
        if (w_rti_ok)
            w_flags_nxt = r_sflags;
        else if (bus.flags_wr_en)
            w_flags_nxt = bus.flags_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_RUN;
            r_pc      <= RESET_VECTOR;
            r_epc     <= '0;
            r_flags   <= 4'h0;
            r_sflags  <= 4'h0;
            r_in_isr  <= 1'b0;
            r_irq_ack <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_commit) begin
                        r_pc    <= w_pc_nxt;
                        r_flags <= w_flags_nxt;
                        if (w_rti_ok)
                            r_in_isr <= 1'b0;
                        if (w_take_irq) begin
                            r_epc     <= w_pc_nxt;
                            r_sflags  <= w_flags_nxt;
                            r_state   <= S_IRQ;
                            r_irq_ack <= 1'b1;
                        end else if (bus.halt) begin
                            r_state <= S_HALT;
                        end
                    end
                end
                S_HALT: begin
                    if (bus.irq_req && !r_in_isr) begin
                        r_epc     <= r_pc;
                        r_sflags  <= r_flags;
                        r_state   <= S_IRQ;
                        r_irq_ack <= 1'b1;
                    end else if (bus.resume) begin
                        r_state <= S_RUN;
                    end
                end
                S_IRQ: begin
                    r_pc      <= IRQ_VECTOR;
                    r_in_isr  <= 1'b1;
                    r_irq_ack <= 1'b0;
                    r_state   <= S_RUN;
                end
                default: begin
                    r_state   <= S_RUN;
                    r_irq_ack <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc        = r_pc;
    assign bus.commit    = w_commit;
    assign bus.halted    = (r_state == S_HALT);
    assign bus.in_isr    = r_in_isr;
    assign bus.irq_ack   = r_irq_ack;
    assign bus.flags_out = r_flags;
    assign bus.epc_out   = r_epc;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus
// a randomized run against a behavioural model of the sequencer.
module tb_pc_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pc_sequencer_if #(.ADDR_W(16)) bus ();

    pc_sequencer #(
        .ADDR_W      (16),
        .RESET_VECTOR(16'h0000),
        .IRQ_VECTOR  (16'h0010)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 = running, 1 = halted, 2 = interrupt entry cycle
    int          m_mode;
    logic [15:0] m_pc;
    logic [15:0] m_epc;
    logic [3:0]  m_flags;
    logic [3:0]  m_sflags;
    bit          m_isr;

    task automatic m_reset();
        m_mode   = 0;
        m_pc     = 16'h0000;
        m_epc    = 16'h0000;
        m_flags  = 4'h0;
        m_sflags = 4'h0;
        m_isr    = 1'b0;
    endtask

    task automatic drive(input bit ir, input bit h, input bit j,
                         input logic [15:0] jt, input bit r,
                         input bit fw, input logic [3:0] fi,
                         input bit irq, input bit res);
        bus.im_ready    = ir;
        bus.halt        = h;
        bus.jmp         = j;
        bus.jmp_target  = jt;
        bus.rti         = r;
        bus.flags_wr_en = fw;
        bus.flags_in    = fi;
        bus.irq_req     = irq;
        bus.resume      = res;
        #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 16'h0, 0, 0, 4'h0, 0, 0);
    endtask

    // Advance one clock edge and apply the architectural rules to the model
    task automatic tick();
        logic [15:0] npc;
        logic [3:0]  nf;
        bit          rti_taken;
        if (reset) begin
            case (m_mode)
                0: if (bus.im_ready) begin
                    rti_taken = !bus.halt && bus.rti && m_isr;
                    if (bus.halt)     npc = m_pc + 16'd1;
                    else if (rti_taken) npc = m_epc;
                    else if (bus.jmp) npc = bus.jmp_target;
                    else              npc = m_pc + 16'd1;
                    if (rti_taken)             nf = m_sflags;
                    else if (bus.flags_wr_en)  nf = bus.flags_in;
                    else                       nf = m_flags;
                    if (bus.irq_req && !m_isr) begin
                        m_epc    = npc;
                        m_sflags = nf;
                        m_mode   = 2;
                    end else if (bus.halt) begin
                        m_mode = 1;
                    end
                    if (rti_taken) m_isr = 1'b0;
                    m_pc    = npc;
                    m_flags = nf;
                end
                1: if (bus.irq_req && !m_isr) begin
                    m_epc    = m_pc;
                    m_sflags = m_flags;
                    m_mode   = 2;
                end else if (bus.resume) begin
                    m_mode = 0;
                end
                default: begin
                    m_pc   = 16'h0010;
                    m_isr  = 1'b1;
                    m_mode = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        m_reset();
        checks++;
        if (bus.commit !== 1'b0) begin
            failures++;
            $display("FAIL reset_commit got=%b want=0", bus.commit);
        end
        checks++;
        if ({bus.pc, bus.halted, bus.in_isr, bus.irq_ack,
             bus.flags_out, bus.epc_out} !== {16'h0, 3'b000, 4'h0, 16'h0}) begin
            failures++;
            $display("FAIL reset_state pc=%h halted=%b isr=%b ack=%b flags=%h epc=%h want all zero",
                     bus.pc, bus.halted, bus.in_isr, bus.irq_ack,
                     bus.flags_out, bus.epc_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (bus.commit !== 1'b1 || bus.pc !== 16'(i)) begin
                failures++;
                $display("FAIL seq_%0d pc=%h commit=%b want pc=%h commit=1",
                         i, bus.pc, bus.commit, 16'(i));
            end
            tick();
        end
        checks++;
        if (bus.pc !== 16'h0003 || bus.flags_out !== 4'h0) begin
            failures++;
            $display("FAIL seq_end pc=%h flags=%h want pc=0003 flags=0",
                     bus.pc, bus.flags_out);
        end
    endtask

    task automatic test_jmp_halt();
        idle(); tick();
        idle(); tick();
        drive(1, 0, 1, 16'h0040, 0, 0, 4'h0, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 16'h0040) begin
            failures++;
            $display("FAIL jmp_target got=%h want=0040", bus.pc);
        end
        drive(1, 1, 0, 16'h0, 0, 0, 4'h0, 0, 0);
        tick();
        idle();
        checks++;
        if (bus.pc !== 16'h0041 || bus.halted !== 1'b1 || bus.commit !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry pc=%h halted=%b commit=%b want 0041 1 0",
                     bus.pc, bus.halted, bus.commit);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            tick();
        end
        checks++;
        if (bus.pc !== 16'h0041 || bus.halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold pc=%h halted=%b want 0041 1", bus.pc, bus.halted);
        end
        drive(1, 0, 0, 16'h0, 0, 0, 4'h0, 0, 1);
        tick();
        idle();
        checks++;
        if (bus.halted !== 1'b0 || bus.commit !== 1'b1 || bus.pc !== 16'h0041) begin
            failures++;
            $display("FAIL resume halted=%b commit=%b pc=%h want 0 1 0041",
                     bus.halted, bus.commit, bus.pc);
        end
        tick();
        checks++;
        if (bus.pc !== 16'h0042) begin
            failures++;
            $display("FAIL resume_adv got=%h want=0042", bus.pc);
        end
    endtask

    task automatic test_irq();
        drive(1, 0, 1, 16'h0020, 0, 0, 4'h0, 0, 0);
        tick();
        drive(1, 0, 0, 16'h0, 0, 1, 4'b1010, 1, 0);
        tick();
        drive(1, 0, 0, 16'h0, 0, 0, 4'h0, 1, 0);
        checks++;
        if (bus.epc_out !== 16'h0021 || bus.irq_ack !== 1'b1 ||
            bus.commit !== 1'b0 || bus.flags_out !== 4'b1010) begin
            failures++;
            $display("FAIL irq_entry epc=%h ack=%b commit=%b flags=%b want 0021 1 0 1010",
                     bus.epc_out, bus.irq_ack, bus.commit, bus.flags_out);
        end
        tick();
        checks++;
        if (bus.pc !== 16'h0010 || bus.in_isr !== 1'b1 || bus.irq_ack !== 1'b0) begin
            failures++;
            $display("FAIL irq_vector pc=%h isr=%b ack=%b want 0010 1 0",
                     bus.pc, bus.in_isr, bus.irq_ack);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 16'h0, 0, 1, 4'b0101, 1, 0);
            tick();
            checks++;
            if (bus.irq_ack !== 1'b0 || bus.epc_out !== 16'h0021) begin
                failures++;
                $display("FAIL no_nest_%0d ack=%b epc=%h want 0 0021",
                         i, bus.irq_ack, bus.epc_out);
            end
        end
        drive(1, 0, 0, 16'h0, 1, 1, 4'b1111, 1, 0);
        tick();
        checks++;
        if (bus.pc !== 16'h0021 || bus.flags_out !== 4'b1010 ||
            bus.in_isr !== 1'b0 || bus.irq_ack !== 1'b0) begin
            failures++;
            $display("FAIL rti pc=%h flags=%b isr=%b ack=%b want 0021 1010 0 0",
                     bus.pc, bus.flags_out, bus.in_isr, bus.irq_ack);
        end
        drive(1, 0, 0, 16'h0, 0, 0, 4'h0, 1, 0);
        tick();
        checks++;
        if (bus.irq_ack !== 1'b1 || bus.epc_out !== 16'h0022) begin
            failures++;
            $display("FAIL pending_irq ack=%b epc=%h want 1 0022",
                     bus.irq_ack, bus.epc_out);
        end
        idle(); tick();
        drive(1, 0, 0, 16'h0, 1, 0, 4'h0, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 16'h0022 || bus.in_isr !== 1'b0) begin
            failures++;
            $display("FAIL rti2 pc=%h isr=%b want 0022 0", bus.pc, bus.in_isr);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 16'h0080, 0, 1, 4'h3, 0, 0);
            checks++;
            if (bus.commit !== 1'b0) begin
                failures++;
                $display("FAIL stall_commit_%0d got=%b want=0", i, bus.commit);
            end
            tick();
            checks++;
            if (bus.pc !== 16'h0022 || bus.flags_out !== 4'b1010) begin
                failures++;
                $display("FAIL stall_hold_%0d pc=%h flags=%b want 0022 1010",
                         i, bus.pc, bus.flags_out);
            end
        end
        drive(1, 0, 1, 16'h0080, 0, 0, 4'h0, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 16'h0080) begin
            failures++;
            $display("FAIL stall_release got=%h want=0080", bus.pc);
        end
    endtask

    task automatic test_wrap_rti_nop();
        drive(1, 0, 1, 16'hFFFF, 0, 0, 4'h0, 0, 0);
        tick();
        idle();
        tick();
        checks++;
        if (bus.pc !== 16'h0000) begin
            failures++;
            $display("FAIL wrap got=%h want=0000", bus.pc);
        end
        drive(1, 0, 0, 16'h0, 1, 0, 4'h0, 0, 0);
        tick();
        checks++;
        if (bus.pc !== 16'h0001 || bus.flags_out !== 4'b1010 || bus.in_isr !== 1'b0) begin
            failures++;
            $display("FAIL rti_nop pc=%h flags=%b isr=%b want 0001 1010 0",
                     bus.pc, bus.flags_out, bus.in_isr);
        end
    endtask

    task automatic test_halt_irq();
        drive(1, 1, 0, 16'h0, 0, 0, 4'h0, 1, 0);
        tick();
        idle();
        checks++;
        if (bus.halted !== 1'b0 || bus.irq_ack !== 1'b1 || bus.epc_out !== 16'h0002) begin
            failures++;
            $display("FAIL halt_vs_irq halted=%b ack=%b epc=%h want 0 1 0002",
                     bus.halted, bus.irq_ack, bus.epc_out);
        end
        tick();
        drive(1, 0, 0, 16'h0, 1, 0, 4'h0, 0, 0);
        tick();
        drive(1, 1, 0, 16'h0, 0, 0, 4'h0, 0, 0);
        tick();
        drive(1, 0, 0, 16'h0, 0, 0, 4'h0, 1, 1);
        tick();
        checks++;
        if (bus.irq_ack !== 1'b1 || bus.epc_out !== 16'h0003 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL irq_from_halt ack=%b epc=%h halted=%b want 1 0003 0",
                     bus.irq_ack, bus.epc_out, bus.halted);
        end
        idle(); tick();
        drive(1, 0, 0, 16'h0, 1, 0, 4'h0, 0, 0);
        tick();
    endtask

    task automatic test_halt_reset();
        drive(1, 1, 0, 16'h0, 0, 0, 4'h0, 0, 0);
        tick();
        idle();
        reset = 1'b0;
        #1;
        m_reset();
        checks++;
        if (bus.pc !== 16'h0000 || bus.halted !== 1'b0 || bus.commit !== 1'b0 ||
            bus.flags_out !== 4'h0 || bus.epc_out !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset pc=%h halted=%b commit=%b flags=%h epc=%h want all zero",
                     bus.pc, bus.halted, bus.commit, bus.flags_out, bus.epc_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        checks++;
        if (bus.pc !== 16'h0000 || bus.commit !== 1'b1) begin
            failures++;
            $display("FAIL post_reset pc=%h commit=%b want 0000 1", bus.pc, bus.commit);
        end
        tick();
    endtask

    task automatic test_random();
        logic [40:0] got;
        logic [40:0] exp;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0,
                  $urandom_range(3, 0) == 0, 16'($urandom),
                  $urandom_range(5, 0) == 0, $urandom_range(1, 0) == 1,
                  4'($urandom), $urandom_range(9, 0) == 0,
                  $urandom_range(3, 0) == 0);
            got = {bus.pc, bus.commit, bus.halted, bus.in_isr, bus.irq_ack,
                   bus.flags_out, bus.epc_out, 1'b0};
            exp = {m_pc, (m_mode == 0) && bus.im_ready, m_mode == 1, m_isr,
                   m_mode == 2, m_flags, m_epc, 1'b0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random_%0d got pc=%h c=%b h=%b isr=%b ack=%b f=%h epc=%h want pc=%h c=%b h=%b isr=%b ack=%b f=%h epc=%h",
                         i, got[40:25], got[24], got[23], got[22], got[21],
                         got[20:17], got[16:1], exp[40:25], exp[24], exp[23],
                         exp[22], exp[21], exp[20:17], exp[16:1]);
            end
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_sequential();
        test_jmp_halt();
        test_irq();
        test_stall();
        test_wrap_rti_nop();
        test_halt_irq();
        test_halt_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and control sequencer for the single-cycle core. It owns the PC, the architectural flags register and the interrupt shadow state (EPC, saved flags). It turns the decoder's halt/jmp/rti/flags_wr_en strobes and an external interrupt request into the next fetch address. It also stalls on instruction-memory ready and produces a per-cycle commit strobe that gates register-file and data-memory writes.

Parameters:
ADDR_W, 16, PC / jump-target / EPC width
RESET_VECTOR, 16'h0000, PC value loaded by reset
IRQ_VECTOR, 16'h0010, PC value loaded on interrupt entry

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
im_ready  in  1  instruction memory holds valid data for the current pc
halt  in  1  decoder: current instruction is HALT
jmp  in  1  decoder: current instruction takes a jump or branch (flag condition already resolved)
jmp_target  in  ADDR_W  jump destination
rti  in  1  decoder: current instruction is RTI
flags_wr_en  in  1  decoder: current instruction updates flags
flags_in  in  4  new flag value from the ALU
irq_req  in  1  level interrupt request
resume  in  1  leave HALT state
pc  out  ADDR_W  instruction-memory fetch address
commit  out  1  current instruction retires this cycle
halted  out  1  state == HALT
in_isr  out  1  interrupt service in progress
irq_ack  out  1  one-cycle pulse on interrupt entry
flags_out  out  4  architectural flags
epc_out  out  ADDR_W  saved return address

Behaviour:
- Reset (reset=0, async): pc=RESET_VECTOR, state=RUN, flags_out=0, epc_out=0, saved_flags=0, in_isr=0, irq_ack=0, halted=0. commit is forced to 0 while reset is low.
- States: RUN, HALT, IRQ_ENTRY. halted = (state==HALT).
- commit = reset && state==RUN && im_ready. This output is combinational.
- RUN, im_ready=0: pc, flags and state hold; no side effects.
- RUN, commit=1: next-PC priority is halt > rti > jmp > sequential.
  - halt: pc<=pc+1, state<=HALT.
  - rti with in_isr=1: pc<=epc_out, flags<=saved_flags, in_isr<=0.
  - rti with in_isr=0: treated as a NOP (pc+1, flags unchanged).
  - jmp: pc<=jmp_target.
  - otherwise: pc<=pc+1.
- Flags on commit: a valid rti restores flags and ignores flags_wr_en. Otherwise flags_wr_en=1 loads flags_in.
- Interrupt check in RUN: if commit && irq_req && in_isr==0 (value before this edge):
  - epc<=computed next pc (including a halt's pc+1).
  - saved_flags<=computed next flags.
  - state<=IRQ_ENTRY; pc keeps the computed next pc this edge.
  - If halt is also set, the interrupt wins: state goes to IRQ_ENTRY, not HALT.
- HALT: commit=0, pc holds.
  - irq_req && !in_isr: epc<=pc, saved_flags<=flags, state<=IRQ_ENTRY.
  - Else resume=1: state<=RUN.
  - The interrupt has priority over resume.
- IRQ_ENTRY (exactly one cycle): commit=0, irq_ack=1 (registered, high only during this state), pc<=IRQ_VECTOR, in_isr<=1, state<=RUN.
- Nesting: irq_req is ignored while in_isr=1. After a valid rti, a pending irq is taken at the next commit, not on the rti edge.
- Arithmetic: pc+1 is modulo 2^ADDR_W, so 16'hFFFF wraps to 16'h0000.
- Reset asserted mid-operation (any state) returns everything to reset values immediately. The first commit after reset release fetches RESET_VECTOR.

Test Plan:
- Reset, im_ready=1, no control for 3 cycles -> pc 0,1,2,3; commit=1 each cycle; flags=0.
- pc=16'h0005, jmp=1, jmp_target=16'h0040; next cycle halt=1 -> pc=16'h0040, then 16'h0041 with halted=1 and commit=0. Hold resume=0 for 4 cycles -> pc stays 16'h0041. Pulse resume -> RUN, pc advances to 16'h0042.
- pc=16'h0020, flags_wr_en=1, flags_in=4'b1010, irq_req=1 -> epc=16'h0021, saved_flags=4'b1010, one IRQ_ENTRY cycle with irq_ack=1 and commit=0, then pc=16'h0010 and in_isr=1. Later rti -> pc=16'h0021, flags=4'b1010, in_isr=0.
- In ISR, irq_req held high -> no re-entry. After rti, a still-pending irq enters on the next commit with epc=16'h0022.
- im_ready low for 2 cycles with jmp asserted -> pc frozen and commit=0; jump taken only on the cycle im_ready=1.
- pc=16'hFFFF sequential -> pc=16'h0000. rti with in_isr=0 -> pc+1, flags unchanged. Assert reset from HALT -> pc=RESET_VECTOR, state=RUN asynchronously.
